inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 20 ++
 rtl/inst_fetch_pc_next.sv | 39 +++
 rtl/inst_fetch.sv | 111 +++++++++++
 tb/tb_inst_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: field positions,
// FSM state encoding and default reset PC.
package inst_fetch_pkg;

    localparam int OP_SIZE     = 6;
    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 26;
    localparam int FUNCODE_MSB = 5;
    localparam int FUNCODE_LSB = 0;
    localparam int JIDX_W      = 26;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } fetchState_e;

endpackage

// File: rtl/inst_fetch_pc_next.sv
// Next-PC selection: jump beats a taken branch, which beats sequential flow.
module pc_next
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [JIDX_W-1:0] instIdx,
    input  logic [31:0]       imm_ext,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    output logic [ADDR_W-1:0] npc
);

    logic [ADDR_W-1:0] immShift_s;
    logic [ADDR_W-1:0] jumpTarget_s;
    logic [ADDR_W-1:0] branchTarget_s;

    // Candidate targets; arithmetic wraps at the address width
    always_comb begin
        immShift_s     = ADDR_W'({imm_ext, 2'b00});
        jumpTarget_s   = {pc_plus4[ADDR_W-1:JIDX_W+2], instIdx, 2'b00};
        branchTarget_s = pc_plus4 + immShift_s;
    end

    // Priority select of the next PC
    always_comb begin
        npc = pc_plus4;
        if (jump) begin
            npc = jumpTarget_s;
        end else if (branch && zero) begin
            npc = branchTarget_s;
        end else begin
            npc = pc_plus4;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: BOOT -> FETCH (wait for ack) -> HOLD (wait for
// consumer), holding one instruction at a time for a single-cycle datapath.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    input  logic               inst_ready,
    input  logic               branch,
    input  logic               zero,
    input  logic               jump,
    input  logic [31:0]        imm_ext,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [OP_SIZE-1:0] opcode,
    output logic [OP_SIZE-1:0] funcode,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4
);

    localparam logic [ADDR_W-1:0] PC_ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] RESET_PC_W    = ADDR_W'(RESET_PC) & PC_ALIGN_MASK;

    fetchState_e       state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [31:0]       inst_r;
    logic              imemReq_r;
    logic              instValid_r;
    logic [ADDR_W-1:0] pcPlus4_s;
    logic [ADDR_W-1:0] npc_s;

    // Sequential successor of the current PC
    always_comb begin
        pcPlus4_s = pc_r + ADDR_W'(32'd4);
    end

    pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc_plus4 (pcPlus4_s),
        .instIdx  (inst_r[JIDX_W-1:0]),
        .imm_ext  (imm_ext),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .npc      (npc_s)
    );

    // Fetch FSM with registered request/valid; acks outside FETCH never land
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= BOOT;
            pc_r        <= RESET_PC_W;
            inst_r      <= 32'h0000_0000;
            imemReq_r   <= 1'b0;
            instValid_r <= 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    state_r     <= FETCH;
                    imemReq_r   <= 1'b1;
                    instValid_r <= 1'b0;
                end
                FETCH: begin
                    if (imem_ack) begin
                        inst_r      <= imem_rdata;
                        state_r     <= HOLD;
                        imemReq_r   <= 1'b0;
                        instValid_r <= 1'b1;
                    end else begin
                        imemReq_r   <= 1'b1;
                        instValid_r <= 1'b0;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        pc_r        <= npc_s & PC_ALIGN_MASK;
                        state_r     <= FETCH;
                        imemReq_r   <= 1'b1;
                        instValid_r <= 1'b0;
                    end else begin
                        imemReq_r   <= 1'b0;
                        instValid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= BOOT;
                    imemReq_r   <= 1'b0;
                    instValid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = imemReq_r;
    assign imem_addr  = pc_r;
    assign pc         = pc_r;
    assign pc_plus4   = pcPlus4_s;
    assign inst_valid = instValid_r;
    assign inst       = inst_r;
    assign opcode     = inst_r[OPCODE_MSB:OPCODE_LSB];
    assign funcode    = inst_r[FUNCODE_MSB:FUNCODE_LSB];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with an address/instruction scoreboard.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic               inst_ready;
    logic               branch;
    logic               zero;
    logic               jump;
    logic [31:0]        imm_ext;
    logic               inst_valid;
    logic [31:0]        inst;
    logic [OP_SIZE-1:0] opcode;
    logic [OP_SIZE-1:0] funcode;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] expAddrQ[$];
    logic [31:0] expInstQ[$];
    logic [31:0] mPc;
    logic [31:0] mInst;

    inst_fetch #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_ready (inst_ready),
        .branch     (branch),
        .zero       (zero),
        .jump       (jump),
        .imm_ext    (imm_ext),
        .inst_valid (inst_valid),
        .inst       (inst),
        .opcode     (opcode),
        .funcode    (funcode),
        .pc         (pc),
        .pc_plus4   (pc_plus4)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelNpc(input logic [31:0] p, input logic [31:0] w,
                                             input logic br, input logic z, input logic j,
                                             input logic [31:0] imm);
        logic [31:0] p4;
        p4 = p + 32'd4;
        if (j) return {p4[31:28], w[25:0], 2'b00};
        if (br && z) return p4 + (imm << 2);
        return p4;
    endfunction

    // Wait for a request, optionally stall the ack, then deliver the word
    task automatic fetchOne(input string tag, input logic [31:0] addr,
                            input logic [31:0] word, input int waitN);
        int n;
        n = 0;
        expAddrQ.push_back(addr);
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        for (int i = 0; i < waitN; i++) begin
            check({tag, "_stall_addr"}, imem_addr, addr);
            check({tag, "_stall_valid"}, 32'(inst_valid), 32'd0);
            @(negedge clk);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        expInstQ.push_back(word);
        check({tag, "_addr"}, imem_addr, expAddrQ.pop_front());
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check({tag, "_valid"}, 32'(inst_valid), 32'd1);
        check({tag, "_req_low"}, 32'(imem_req), 32'd0);
        check({tag, "_inst"}, inst, expInstQ.pop_front());
        mPc   = addr;
        mInst = word;
    endtask

    // Consume the held instruction with the given control decode
    task automatic consume(input string tag, input logic br, input logic z,
                           input logic j, input logic [31:0] imm);
        check({tag, "_pc_held"}, pc, mPc);
        inst_ready = 1'b1;
        branch     = br;
        zero       = z;
        jump       = j;
        imm_ext    = imm;
        @(negedge clk);
        inst_ready = 1'b0;
        branch     = 1'($urandom);
        zero       = 1'($urandom);
        jump       = 1'($urandom);
        imm_ext    = $urandom;
        mPc = modelNpc(mPc, mInst, br, z, j, imm);
        check({tag, "_npc"}, pc, mPc);
        check({tag, "_valid_low"}, 32'(inst_valid), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        jump       = 1'b0;
        imm_ext    = 32'h0;
        mPc        = 32'h0;
        mInst      = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);

        // Boot: request must first appear in the second cycle after release
        rst_n = 1'b1;
        check("boot_req_cycle1", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("boot_req_cycle2", 32'(imem_req), 32'd1);
        check("boot_addr", imem_addr, 32'h0);
        fetchOne("boot", 32'h0, 32'h2345_67A9, 0);
        check("opcode", 32'(opcode), 32'd8);
        check("funcode", 32'(funcode), 32'h29);

        consume("seq0", 1'b0, 1'b0, 1'b0, 32'h0);
        fetchOne("seq1", 32'h4, 32'h1111_0004, 0);
        consume("seq1", 1'b0, 1'b1, 1'b0, 32'h0000_0040);
        fetchOne("seq2", 32'h8, 32'h1111_0008, 0);
        consume("seq2", 1'b0, 1'b0, 1'b0, 32'h0);
        fetchOne("seq3", 32'hC, 32'h1111_000C, 0);
        consume("seq3", 1'b0, 1'b0, 1'b0, 32'h0);

        fetchOne("br_src", 32'h10, 32'h1000_FFFE, 0);
        consume("br_taken", 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
        fetchOne("br_tgt", 32'h0C, 32'h2222_000C, 0);
        consume("br_back", 1'b0, 1'b0, 1'b0, 32'h0);
        fetchOne("br_src2", 32'h10, 32'h1000_FFFE, 0);
        consume("br_nt", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
        fetchOne("br_nt_tgt", 32'h14, 32'h3333_0014, 0);
        check("pc_plus4_0x14", pc_plus4, 32'h18);

        // Reach 0x1000_0020 with a far branch, then jump with branch also set
        consume("far_br", 1'b1, 1'b1, 1'b0, 32'h0400_0002);
        fetchOne("jmp_src", 32'h1000_0020, 32'h0800_0040, 0);
        consume("jump", 1'b1, 1'b1, 1'b1, 32'h0000_0010);
        fetchOne("ack_stall", 32'h1000_0100, 32'h4444_0100, 5);

        // Consumer stall; acks seen while holding must not disturb inst
        for (int i = 0; i < 4; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'h1234_5678;
            @(negedge clk);
            check("rdy_stall_pc", pc, 32'h1000_0100);
            check("rdy_stall_inst", inst, 32'h4444_0100);
            check("rdy_stall_valid", 32'(inst_valid), 32'd1);
            check("rdy_stall_req", 32'(imem_req), 32'd0);
        end
        imem_ack = 1'b0;

        consume("to_wrap", 1'b1, 1'b1, 1'b0, 32'h3BFF_FFBE);
        fetchOne("wrap_src", 32'hFFFF_FFFC, 32'h5555_FFFC, 0);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        consume("wrap", 1'b0, 1'b0, 1'b0, 32'h0);
        fetchOne("wrap_tgt", 32'h0, 32'h6666_0000, 0);
        consume("pre_rst0", 1'b0, 1'b0, 1'b0, 32'h0);
        fetchOne("pre_rst4", 32'h4, 32'h6666_0004, 0);
        consume("pre_rst8", 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset in the middle of the fetch at 0x8, with a late ack
        check("mid_addr", imem_addr, 32'h8);
        check("mid_req", 32'(imem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", 32'(imem_req), 32'd0);
        check("async_valid", 32'(inst_valid), 32'd0);
        check("async_pc", pc, 32'h0);
        check("async_inst", inst, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0008;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check("late_ack_req", 32'(imem_req), 32'd1);
        check("late_ack_valid", 32'(inst_valid), 32'd0);
        check("late_ack_inst", inst, 32'h0);
        check("late_ack_addr", imem_addr, 32'h0);
        mPc = 32'h0;
        fetchOne("refetch", 32'h0, 32'h7777_0000, 0);
        consume("refetch", 1'b0, 1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
